imm_gen_pipe: RTL and testbench
===============================

# imm_gen_pipe

Pipelined, parametrised immediate generator for the RV core decode stage. Decodes every RV32I immediate format (I, S, B, U, J, plus shift-amount) and sign-extends it to XLEN. A 2-entry output buffer with valid/ready handshakes on both sides lets fetch and execute stall independently. The block flags unsupported opcodes and keeps a saturating count of them for debug.

## Interface

Parameters:
- XLEN, 32, output immediate width; legal values 32 or 64.
- CNT_W, 8, width of the illegal-opcode counter.

Ports (one clock; reset is asynchronous and active-high):
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- inst_valid  input  1  upstream has an instruction.
- inst_ready  output  1  block can accept; equals (occupancy < 2).
- inst  input  32  raw instruction word.
- imm_valid  output  1  head entry valid; equals (occupancy > 0).
- imm_ready  input  1  downstream accepts the head entry.
- imm  output  XLEN  head immediate.
- imm_fmt  output  3  head format: 0 R/none, 1 I, 2 S, 3 B, 4 U, 5 J, 6 shamt, 7 illegal.
- imm_illegal  output  1  head opcode unsupported (imm_fmt == 7).
- illegal_cnt  output  CNT_W  saturating count of illegal instructions accepted.

## Operation

- Push: inst_valid && inst_ready. Pop: imm_valid && imm_ready.
- Decode is combinational on inst; the result is written into the buffer on push.
- Decode by inst[6:0] (s = inst[31]; sext = replicate s up to XLEN):
  - 0000011 load, 1100111 JALR, 0010011 OP-IMM (funct3 not 001/101): fmt 1, sext(inst[31:20]).
  - 0010011 with funct3 001/101: fmt 6, zero-extended shamt. XLEN=32 uses inst[24:20]; XLEN=64 uses inst[25:20].
  - 0100011: fmt 2, sext({inst[31:25], inst[11:7]}).
  - 1100011: fmt 3, sext({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}).
  - 0110111 LUI, 0010111 AUIPC: fmt 4, sext({inst[31:12], 12'b0}). Upper bits are ones when s=1 and XLEN=64.
  - 1101111: fmt 5, sext({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}).
  - 0110011: fmt 0, imm 0.
  - Any other opcode: fmt 7, imm 0, imm_illegal 1.
- Buffer:
  - 2-entry FIFO: write pointer, read pointer, 2-bit occupancy.
  - Order is preserved.
  - Each entry stores {imm, fmt}.
- illegal_cnt:
  - Increments on every push with fmt 7.
  - Holds at 2^CNT_W-1 once reached.
  - Cleared only by rst.

## Timing

- Reset values (asynchronous, immediate on rst=1): occupancy 0, pointers 0, imm_valid 0, inst_ready 1, imm 0, imm_fmt 0, imm_illegal 0, illegal_cnt 0.
- Latency: a push at edge N presents the result with imm_valid=1 after edge N (visible in cycle N+1). There is no same-cycle bypass.
- Throughput: one instruction per cycle while downstream pops every cycle.
- inst_ready depends only on registered occupancy; no combinational path from imm_ready.
- Full (occupancy 2):
  - inst_ready=0.
  - A pop in this cycle still frees the entry, but a push is refused until the next cycle.
- Empty (occupancy 0):
  - imm_valid=0; imm, imm_fmt and imm_illegal hold the last-read values and are don't-care.
  - A pop attempt has no effect.
- Simultaneous push and pop at occupancy 1: occupancy stays 1, the head advances, and the new entry becomes the tail/head correctly.
- Pointers are 1-bit and wrap from 1 to 0.
- Reset mid-operation: all buffered entries are discarded. illegal_cnt resets regardless of the transfer in flight.
- Head outputs are stable while imm_valid=1 and imm_ready=0.

## Test plan

- Reset then single pushes, imm_ready=1, XLEN=32, with no illegal_cnt change:
  - 0xFFC12083 -> imm 0xFFFFFFFC, fmt 1, one cycle later.
  - 0x00512423 -> imm 0x00000008, fmt 2.
  - 0xFE000CE3 -> imm 0xFFFFFFF8, fmt 3.
- U/J/shamt:
  - 0x123450B7 -> imm 0x12345000, fmt 4.
  - 0x001000EF -> imm 0x00000800, fmt 5.
  - 0x01F09093 (slli x1,x1,31) -> imm 0x0000001F, fmt 6.
  - 0x002081B3 (add) -> imm 0, fmt 0.
- Illegal:
  - Push 0xFFFFFFFF three times -> fmt 7 and imm_illegal 1 each time; illegal_cnt = 3.
  - With CNT_W=2, push five times -> illegal_cnt saturates at 3.
- Backpressure:
  - Hold imm_ready=0 and offer 3 instructions back-to-back -> two accepted, then inst_ready=0.
  - Release imm_ready -> outputs emerge in order with no loss or duplication; the third instruction is accepted the cycle after the first pop.
- XLEN=64:
  - 0xFFC12083 -> 0xFFFFFFFFFFFFFFFC.
  - 0x800000B7 -> 0xFFFFFFFF80000000.
  - 0x03F09093 -> shamt 0x3F, fmt 6.
- Reset mid-stream: assert rst with 2 entries buffered -> imm_valid=0, inst_ready=1 and illegal_cnt=0 immediately; after release the next push emerges alone.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe
// Pipelined RV32I immediate generator for the decode stage. Each accepted
// instruction is decoded combinationally and written into a 2-entry FIFO.
// The FIFO head drives the outputs. Unsupported opcodes are flagged, and they
// are counted by a saturating debug counter.
//
// Parameters:
//   XLEN  - immediate width (32 or 64)
//   CNT_W - width of the illegal-opcode counter
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   inst_valid/ready    - upstream handshake (ready = occupancy < 2)
//   inst[31:0]          - raw instruction word
//   imm_valid/ready     - downstream handshake (valid = occupancy > 0)
//   imm[XLEN-1:0]       - head immediate
//   imm_fmt[2:0]        - head format: 0 R, 1 I, 2 S, 3 B, 4 U, 5 J, 6 shamt, 7 illegal
//   imm_illegal         - head format is illegal
//   illegal_cnt         - saturating count of accepted illegal instructions
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inst_valid,
  output logic             inst_ready,
  input  logic [31:0]      inst,
  output logic             imm_valid,
  input  logic             imm_ready,
  output logic [XLEN-1:0]  imm,
  output logic [2:0]       imm_fmt,
  output logic             imm_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_SH  = 3'd6;
  localparam logic [2:0] FMT_ILL = 3'd7;

  // ---------------- decode ----------------
  logic [31:0]     val32;
  logic [2:0]      fmt_dec;
  logic [XLEN-1:0] imm_dec;

  always_comb begin
    val32   = '0;
    fmt_dec = FMT_ILL;
    case (inst[6:0])
      7'b0000011, 7'b1100111: begin
        fmt_dec = FMT_I;
        val32   = {{20{inst[31]}}, inst[31:20]};
      end
      7'b0010011: begin
        if (inst[14:12] == 3'b001 || inst[14:12] == 3'b101) begin
          fmt_dec = FMT_SH;
          // RV64 shift amounts use one more bit of the instruction.
          if (XLEN == 64) val32 = {26'd0, inst[25:20]};
          else            val32 = {27'd0, inst[24:20]};
        end else begin
          fmt_dec = FMT_I;
          val32   = {{20{inst[31]}}, inst[31:20]};
        end
      end
      7'b0100011: begin
        fmt_dec = FMT_S;
        val32   = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      end
      7'b1100011: begin
        fmt_dec = FMT_B;
        val32   = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        fmt_dec = FMT_U;
        val32   = {inst[31:12], 12'd0};
      end
      7'b1101111: begin
        fmt_dec = FMT_J;
        val32   = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      end
      7'b0110011: begin
        fmt_dec = FMT_R;
      end
      default: begin
        fmt_dec = FMT_ILL;
      end
    endcase
  end

  // Every 32-bit value above is already correctly signed or zero-extended.
  // Zero-extended values always have bit 31 clear, so the same extension
  // works for all formats. The replication count is never zero.
  assign imm_dec = {{(XLEN-31){val32[31]}}, val32[30:0]};

  // ---------------- buffer control ----------------
  logic       wr_ptr_reg, wr_ptr_next;
  logic       rd_ptr_reg, rd_ptr_next;
  logic [1:0] occ_reg, occ_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic       push, pop;

  // inst_ready is a function of registered occupancy only. When the buffer is
  // full, a pop in the same cycle does not let a new instruction in.
  assign inst_ready = (occ_reg != 2'd2);
  assign imm_valid  = (occ_reg != 2'd0);
  assign push       = inst_valid && inst_ready;
  assign pop        = imm_valid && imm_ready;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    occ_next    = occ_reg;
    cnt_next    = cnt_reg;
    if (push) wr_ptr_next = ~wr_ptr_reg;
    if (pop)  rd_ptr_next = ~rd_ptr_reg;
    case ({push, pop})
      2'b10:   occ_next = occ_reg + 2'd1;
      2'b01:   occ_next = occ_reg - 2'd1;
      default: occ_next = occ_reg;
    endcase
    if (push && fmt_dec == FMT_ILL && cnt_reg != {CNT_W{1'b1}})
      cnt_next = cnt_reg + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      occ_reg    <= 2'd0;
      cnt_reg    <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      occ_reg    <= occ_next;
      cnt_reg    <= cnt_next;
    end
  end

  // ---------------- storage ----------------
  // The entries are cleared on reset. Because of this, the head outputs read 0
  // right after reset.
  logic [XLEN-1:0] entry_imm [2];
  logic [2:0]      entry_fmt [2];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_entry
      logic [XLEN-1:0] imm_reg;
      logic [2:0]      fmt_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          imm_reg <= '0;
          fmt_reg <= FMT_R;
        end else if (push && wr_ptr_reg == 1'(gi)) begin
          imm_reg <= imm_dec;
          fmt_reg <= fmt_dec;
        end
      end

      assign entry_imm[gi] = imm_reg;
      assign entry_fmt[gi] = fmt_reg;
    end
  endgenerate

  assign imm         = entry_imm[rd_ptr_reg];
  assign imm_fmt     = entry_fmt[rd_ptr_reg];
  assign imm_illegal = (imm_fmt == FMT_ILL);
  assign illegal_cnt = cnt_reg;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe. It uses three instances: XLEN=32/CNT_W=8,
// XLEN=32/CNT_W=2 and XLEN=64/CNT_W=8.
module tb_imm_gen_pipe;

  typedef struct packed {
    logic [63:0] imm;
    logic [2:0]  fmt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        iv   [3];
  logic [31:0] ins  [3];
  logic        ir   [3];
  logic        ordy [3];
  logic        ovld [3];
  logic [2:0]  fmt  [3];
  logic        ill  [3];
  logic [63:0] imm64[3];
  logic [31:0] imm_a, imm_b;
  logic [63:0] imm_c;
  logic [7:0]  cnt_a, cnt_c;
  logic [1:0]  cnt_b;

  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];

  int n_checks = 0;
  int n_fail   = 0;
  int pops [3];
  logic        held     [3];
  logic [63:0] held_imm [3];
  logic [2:0]  held_fmt [3];
  exp_t mon_e;
  bit   mon_have;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .CNT_W(8)) u_a (
    .clk(clk), .rst(rst), .inst_valid(iv[0]), .inst_ready(ordy[0]), .inst(ins[0]),
    .imm_valid(ovld[0]), .imm_ready(ir[0]), .imm(imm_a), .imm_fmt(fmt[0]),
    .imm_illegal(ill[0]), .illegal_cnt(cnt_a));

  imm_gen_pipe #(.XLEN(32), .CNT_W(2)) u_b (
    .clk(clk), .rst(rst), .inst_valid(iv[1]), .inst_ready(ordy[1]), .inst(ins[1]),
    .imm_valid(ovld[1]), .imm_ready(ir[1]), .imm(imm_b), .imm_fmt(fmt[1]),
    .imm_illegal(ill[1]), .illegal_cnt(cnt_b));

  imm_gen_pipe #(.XLEN(64), .CNT_W(8)) u_c (
    .clk(clk), .rst(rst), .inst_valid(iv[2]), .inst_ready(ordy[2]), .inst(ins[2]),
    .imm_valid(ovld[2]), .imm_ready(ir[2]), .imm(imm_c), .imm_fmt(fmt[2]),
    .imm_illegal(ill[2]), .illegal_cnt(cnt_c));

  assign imm64[0] = {32'd0, imm_a};
  assign imm64[1] = {32'd0, imm_b};
  assign imm64[2] = imm_c;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic push_exp(input int d, input exp_t e);
    case (d)
      0:       qa.push_back(e);
      1:       qb.push_back(e);
      default: qc.push_back(e);
    endcase
  endtask

  // One offered cycle: drive the word, sample acceptance away from the edge,
  // and record the expectation once the edge has taken it.
  task automatic cyc(input int d, input logic [31:0] i, input logic [63:0] ei,
                     input logic [2:0] ef, output logic acc);
    ins[d] = i;
    iv[d]  = 1'b1;
    @(negedge clk);
    acc = ordy[d];
    @(posedge clk);
    #1;
    iv[d] = 1'b0;
    if (acc) push_exp(d, '{imm: ei, fmt: ef});
  endtask

  // Single push into an empty buffer with imm_ready=1. It checks that there is
  // no bypass and that the result shows up one cycle later.
  task automatic single(input int d, input logic [31:0] i, input logic [63:0] ei,
                        input logic [2:0] ef);
    logic acc;
    ins[d] = i;
    iv[d]  = 1'b1;
    @(negedge clk);
    acc = ordy[d];
    check($sformatf("no_bypass d%0d %h", d, i), 64'(ovld[d]), 64'd0);
    @(posedge clk);
    #1;
    iv[d] = 1'b0;
    check($sformatf("accept d%0d %h", d, i), 64'(acc), 64'd1);
    if (acc) push_exp(d, '{imm: ei, fmt: ef});
    @(negedge clk);
    check($sformatf("latency d%0d %h", d, i), 64'(ovld[d]), 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    repeat (4) @(posedge clk);
    #1;
  endtask

  // Monitor: a pop happens at the next edge whenever valid&&ready is true now.
  always @(negedge clk) begin
    if (rst) begin
      for (int d = 0; d < 3; d++) held[d] = 1'b0;
    end else begin
      for (int d = 0; d < 3; d++) begin
        if (ovld[d] && held[d]) begin
          check($sformatf("hold_imm d%0d", d), imm64[d], held_imm[d]);
          check($sformatf("hold_fmt d%0d", d), 64'(fmt[d]), 64'(held_fmt[d]));
        end
        if (ovld[d] && ir[d]) begin
          pops[d]++;
          mon_have = 1'b0;
          case (d)
            0: if (qa.size() > 0) begin mon_e = qa.pop_front(); mon_have = 1'b1; end
            1: if (qb.size() > 0) begin mon_e = qb.pop_front(); mon_have = 1'b1; end
            default: if (qc.size() > 0) begin mon_e = qc.pop_front(); mon_have = 1'b1; end
          endcase
          if (!mon_have) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_output d%0d: got imm %h fmt %0d, expected nothing", d, imm64[d], fmt[d]);
          end else begin
            check($sformatf("imm d%0d", d), imm64[d], mon_e.imm);
            check($sformatf("fmt d%0d", d), 64'(fmt[d]), 64'(mon_e.fmt));
            check($sformatf("illegal d%0d", d), 64'(ill[d]), 64'(mon_e.fmt == 3'd7));
          end
        end
        held[d]     = ovld[d] && !ir[d];
        held_imm[d] = imm64[d];
        held_fmt[d] = fmt[d];
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic acc;
    int   p0;
    for (int d = 0; d < 3; d++) begin
      iv[d] = 1'b0; ins[d] = '0; ir[d] = 1'b1; pops[d] = 0; held[d] = 1'b0;
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("rst_valid d%0d", d), 64'(ovld[d]), 64'd0);
      check($sformatf("rst_ready d%0d", d), 64'(ordy[d]), 64'd1);
      check($sformatf("rst_imm d%0d", d), imm64[d], 64'd0);
      check($sformatf("rst_fmt d%0d", d), 64'(fmt[d]), 64'd0);
      check($sformatf("rst_ill d%0d", d), 64'(ill[d]), 64'd0);
    end
    check("rst_cnt a", 64'(cnt_a), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // XLEN=32 formats
    single(0, 32'hFFC12083, 64'h00000000FFFFFFFC, 3'd1);
    single(0, 32'h00512423, 64'h0000000000000008, 3'd2);
    single(0, 32'hFE000CE3, 64'h00000000FFFFFFF8, 3'd3);
    single(0, 32'h123450B7, 64'h0000000012345000, 3'd4);
    single(0, 32'hFFFFF097, 64'h00000000FFFFF000, 3'd4);
    single(0, 32'h001000EF, 64'h0000000000000800, 3'd5);
    single(0, 32'h01F09093, 64'h000000000000001F, 3'd6);
    single(0, 32'h002081B3, 64'h0000000000000000, 3'd0);
    drain();
    check("cnt_a no_change", 64'(cnt_a), 64'd0);

    // Illegal opcodes
    for (int k = 0; k < 3; k++) single(0, 32'hFFFFFFFF, 64'd0, 3'd7);
    drain();
    check("cnt_a three", 64'(cnt_a), 64'd3);

    for (int k = 0; k < 5; k++) begin
      cyc(1, 32'hFFFFFFFF, 64'd0, 3'd7, acc);
      check($sformatf("b_accept %0d", k), 64'(acc), 64'd1);
    end
    drain();
    check("cnt_b saturate", 64'(cnt_b), 64'd3);

    // XLEN=64
    single(2, 32'hFFC12083, 64'hFFFFFFFFFFFFFFFC, 3'd1);
    single(2, 32'h800000B7, 64'hFFFFFFFF80000000, 3'd4);
    single(2, 32'h03F09093, 64'h000000000000003F, 3'd6);
    single(2, 32'hFE000CE3, 64'hFFFFFFFFFFFFFFF8, 3'd3);
    drain();

    // Backpressure on instance A
    ir[0] = 1'b0;
    cyc(0, 32'h00512423, 64'h8, 3'd2, acc);
    check("bp_accept1", 64'(acc), 64'd1);
    cyc(0, 32'h123450B7, 64'h12345000, 3'd4, acc);
    check("bp_accept2", 64'(acc), 64'd1);
    cyc(0, 32'h001000EF, 64'h800, 3'd5, acc);
    check("bp_full_refuse", 64'(acc), 64'd0);
    ir[0] = 1'b1;
    cyc(0, 32'h001000EF, 64'h800, 3'd5, acc);
    check("bp_refuse_pop_cycle", 64'(acc), 64'd0);
    cyc(0, 32'h001000EF, 64'h800, 3'd5, acc);
    check("bp_accept_after_pop", 64'(acc), 64'd1);
    drain();
    check("bp_drained", 64'(qa.size()), 64'd0);

    // Reset with two entries buffered
    ir[0] = 1'b0;
    cyc(0, 32'hFFC12083, 64'hFFFFFFFC, 3'd1, acc);
    cyc(0, 32'h002081B3, 64'h0, 3'd0, acc);
    check("mid_two_buffered", 64'(ordy[0]), 64'd0);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 64'(ovld[0]), 64'd0);
    check("mid_rst_ready", 64'(ordy[0]), 64'd1);
    check("mid_rst_cnt", 64'(cnt_a), 64'd0);
    qa.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    ir[0] = 1'b1;
    p0 = pops[0];
    single(0, 32'h00512423, 64'h8, 3'd2);
    drain();
    check("mid_single_pop", 64'(pops[0] - p0), 64'd1);
    check("final_qa_empty", 64'(qa.size()), 64'd0);
    check("final_qb_empty", 64'(qb.size()), 64'd0);
    check("final_qc_empty", 64'(qc.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
